cga_vgate_regs: RTL and testbench
=================================

# cga_vgate_regs

Parametrised CGA/Tandy video gate-array register block: decodes the 3Dx I/O window, holds mode/color registers plus an indexed Tandy register file with an N-entry palette RAM, reports synchronized status, and optionally stretches CPU video-memory cycles with wait states. It sits between the ISA bus front end and the CRTC/sequencer/pixel path inside the CGA top level. It supersedes the ad-hoc level-triggered register writes with edge-qualified writes, indexed access and a full palette.

## Interface
- IO_BASE_ADDR, 16'h3D0, base of 16-byte I/O window
- PAL_ENTRIES, 16, palette depth (power of 2, 2..16)
- PAL_WIDTH, 4, palette entry width (IRGB)
- WAIT_CYCLES, 4, wait states per memory access (1..15)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- bus_a  in  15  ISA address
- bus_ior_l / bus_iow_l  in  1  I/O strobes, async, active low
- bus_memr_l / bus_memw_l  in  1  memory strobes, async, active low
- mem_cs  in  1  framebuffer window hit
- bus_aen  in  1  DMA address enable (blocks decode)
- bus_d  in  8  write data
- bus_out  out  8  read data
- bus_dir  out  1  high while this block drives a read
- bus_rdy  out  1  ISA ready
- vsync_l, display_enable  in  1  from CRTC, async to bus timing
- control_reg, color_reg  out  8  3D8/3D9 contents
- tandy_mode  out  4  indexed reg 3
- border_col  out  4  indexed reg 2
- pal_mask  out  4  indexed reg 1
- pal_rd_idx  in  log2(PAL_ENTRIES)  pixel-side palette address
- pal_rd_data  out  PAL_WIDTH  palette data, registered

## Operation
- All bus strobes pass through 2-flop synchronizers; writes act once, on the cycle after synced iow falls (falling edge detect). Holding iow low never re-writes.
- Decode valid only when bus_aen=0 and bus_a[14:4]==IO_BASE_ADDR[14:4].
- Offset 8 write: control_reg. Offset 9 write: color_reg.
- Offset A write: index register (5 bits, bus_d[4:0]). Offset A read: status {4'b1111, vsync_s, 2'b10, ~de_s}, vsync_s/de_s double-flopped.
- Offset E write: data to indexed reg. Index 1 mask, 2 border, 3 tandy_mode, 0x10+i palette[i] (i<PAL_ENTRIES; higher i ignored). Other indices ignored.
- Palette auto-increment: after an offset-E write with index[4]=1, index increments within 0x10..0x1F, wrapping 0x1F→0x10. Non-palette indices do not increment.
- bus_dir=1 only for offset-A reads and CRTC-independent ranges owned here; bus_out=0 otherwise.
- Palette reads: pal_rd_data = palette[pal_rd_idx] one cycle later. Same-cycle write and read of one entry returns old data.

## Timing
- Reset values: control_reg 8'h29, color_reg 0, index 0, border_col 0, tandy_mode 0, pal_mask 4'hF, palette[i]=i (truncated to PAL_WIDTH), pal_rd_data 0, bus_rdy 1, bus_dir 0, bus_out 0.
- Write latency: register visible 3 clocks after raw iow falls (2 sync + 1 edge).
- Status latency: vsync/de reflected 2 clocks after change.
- Reset asserted mid-write: reset wins, write discarded; edge detector restarts so a strobe still low after reset does not write.
- bus_rdy: see Configuration.

## Configuration
- CGA_BUS_WAIT_EN defined: FSM IDLE→WAIT→READY. IDLE: synced (memr|memw)&mem_cs falls → WAIT, bus_rdy=0, counter=WAIT_CYCLES. WAIT: decrement; at 1 → READY, bus_rdy=1. READY: hold until strobe released → IDLE. Reset → IDLE, bus_rdy=1.
- Undefined: bus_rdy tied 1, no FSM or counter synthesized.

## Structure
- Shared package cga_pkg: register offsets (8,9,A,E), index constants (IDX_MASK=1, IDX_BORDER=2, IDX_MODE=3, IDX_PAL_BASE=5'h10), control reset value, wait-FSM state enum.
- One sub-module: cga_palette_ram (1 write port, 1 registered read port, reset-initialized identity contents).

## Test plan
- Reset, then read offset A with vsync_l=0, display_enable=1 → bus_out 8'hF4, bus_dir=1; control_reg 8'h29.
- Write 3DA=0x10 then 3DE 0x0C,0x0A,0x05 → palette[0..2]=C,A,5, index=0x13; pal_rd_idx=1 → pal_rd_data 4'hA next clock.
- Index 0x1F, write 3DE=0x7 → palette[15]=7, index wraps to 0x10.
- Hold iow low 20 clocks on 3D8 with bus_d changing 0x1A→0x0A → control_reg 0x1A only.
- bus_aen=1 during 3D9 write 0x3F → color_reg unchanged 0.
- CGA_BUS_WAIT_EN, WAIT_CYCLES=4: memr low with mem_cs → bus_rdy low exactly 4 clocks after sync, high until release; reset mid-WAIT → bus_rdy 1 next clock.

Source files
------------

// File: rtl/cga_pkg.sv
// Shared constants for the CGA/Tandy video gate-array register block:
// I/O offsets, indexed-register numbers, reset values and the wait-state FSM encoding.
package cga_pkg;

    localparam logic [3:0] OFS_CONTROL = 4'h8;
    localparam logic [3:0] OFS_COLOR   = 4'h9;
    localparam logic [3:0] OFS_STATUS  = 4'hA;
    localparam logic [3:0] OFS_DATA    = 4'hE;

    localparam logic [4:0] IDX_MASK     = 5'd1;
    localparam logic [4:0] IDX_BORDER   = 5'd2;
    localparam logic [4:0] IDX_MODE     = 5'd3;
    localparam logic [4:0] IDX_PAL_BASE = 5'h10;

    localparam logic [7:0] CONTROL_RST = 8'h29;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        WAIT_WAIT,
        WAIT_READY
    } wait_state_t;

    // Palette index stays inside 0x10..0x1F, wrapping 0x1F -> 0x10.
    function automatic logic [4:0] pal_next_index(input logic [3:0] low);
        return IDX_PAL_BASE | {1'b0, low + 4'd1};
    endfunction

endpackage

// File: rtl/cga_palette_ram.sv
// Palette storage: one write port, one registered read port; reset loads the
// identity map (entry i holds i truncated to WIDTH).
module cga_palette_ram #(
    parameter int ENTRIES = 16,
    parameter int WIDTH   = 4,
    parameter int AW      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_reg [ENTRIES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_reg[i] <= WIDTH'(i);
            end
        end else if (we) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // Read samples the pre-write contents, so a same-cycle write returns old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem_reg[rd_addr];
        end
    end

endmodule

// File: rtl/cga_vgate_regs.sv
// CGA/Tandy gate-array register block: 3Dx decode, mode/color/index registers,
// palette, synchronized status. Define CGA_BUS_WAIT_EN to add memory wait states.
module cga_vgate_regs
    import cga_pkg::*;
#(
    parameter logic [15:0] IO_BASE_ADDR = 16'h3D0,
    parameter int          PAL_ENTRIES  = 16,
    parameter int          PAL_WIDTH    = 4,
    parameter int          WAIT_CYCLES  = 4,
    localparam int         PAL_AW       = (PAL_ENTRIES > 1) ? $clog2(PAL_ENTRIES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [14:0]          bus_a,
    input  logic                 bus_ior_l,
    input  logic                 bus_iow_l,
    input  logic                 bus_memr_l,
    input  logic                 bus_memw_l,
    input  logic                 mem_cs,
    input  logic                 bus_aen,
    input  logic [7:0]           bus_d,
    output logic [7:0]           bus_out,
    output logic                 bus_dir,
    output logic                 bus_rdy,
    input  logic                 vsync_l,
    input  logic                 display_enable,
    output logic [7:0]           control_reg,
    output logic [7:0]           color_reg,
    output logic [3:0]           tandy_mode,
    output logic [3:0]           border_col,
    output logic [3:0]           pal_mask,
    input  logic [PAL_AW-1:0]    pal_rd_idx,
    output logic [PAL_WIDTH-1:0] pal_rd_data
);

    // Sync bit order {display_enable, vsync_l, ior_l, iow_l}. iow resets to
    // "held low" so a strobe still asserted after reset cannot look like a new edge.
    localparam logic [3:0] SYNC_RST = 4'b0110;

    logic [3:0] sync1_reg, sync2_reg;
    logic       iow_prev_reg;
    logic [4:0] index_reg;

    logic       iow_s, ior_s, vsync_s, de_s;
    logic       iow_fall, dec_hit, wr_hit, rd_hit, pal_we;
    logic [7:0] status;

    assign iow_s   = sync2_reg[0];
    assign ior_s   = sync2_reg[1];
    assign vsync_s = sync2_reg[2];
    assign de_s    = sync2_reg[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg    <= SYNC_RST;
            sync2_reg    <= SYNC_RST;
            iow_prev_reg <= 1'b0;
        end else begin
            sync1_reg    <= {display_enable, vsync_l, bus_ior_l, bus_iow_l};
            sync2_reg    <= sync1_reg;
            iow_prev_reg <= iow_s;
        end
    end

    assign iow_fall = iow_prev_reg & ~iow_s;
    assign dec_hit  = ~bus_aen && (bus_a[14:4] == IO_BASE_ADDR[14:4]);
    assign wr_hit   = iow_fall & dec_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            control_reg <= CONTROL_RST;
            color_reg   <= 8'h00;
            index_reg   <= 5'd0;
            border_col  <= 4'h0;
            tandy_mode  <= 4'h0;
            pal_mask    <= 4'hF;
        end else if (wr_hit) begin
            case (bus_a[3:0])
                OFS_CONTROL: control_reg <= bus_d;
                OFS_COLOR:   color_reg   <= bus_d;
                OFS_STATUS:  index_reg   <= bus_d[4:0];
                OFS_DATA: begin
                    if (index_reg[4]) begin
                        index_reg <= pal_next_index(index_reg[3:0]);
                    end
                    case (index_reg)
                        IDX_MASK:   pal_mask   <= bus_d[3:0];
                        IDX_BORDER: border_col <= bus_d[3:0];
                        IDX_MODE:   tandy_mode <= bus_d[3:0];
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Palette slots beyond PAL_ENTRIES are silently dropped but still advance the index.
    assign pal_we = wr_hit && (bus_a[3:0] == OFS_DATA) && index_reg[4]
                    && ({1'b0, index_reg[3:0]} < 5'(PAL_ENTRIES));

    cga_palette_ram #(
        .ENTRIES(PAL_ENTRIES),
        .WIDTH  (PAL_WIDTH),
        .AW     (PAL_AW)
    ) u_palette (
        .clk    (clk),
        .reset  (reset),
        .we     (pal_we),
        .wr_addr(index_reg[PAL_AW-1:0]),
        .wr_data(bus_d[PAL_WIDTH-1:0]),
        .rd_addr(pal_rd_idx),
        .rd_data(pal_rd_data)
    );

    assign status  = {4'b1111, vsync_s, 2'b10, ~de_s};
    assign rd_hit  = ~ior_s && dec_hit && (bus_a[3:0] == OFS_STATUS);
    assign bus_dir = rd_hit;
    assign bus_out = rd_hit ? status : 8'h00;

`ifdef CGA_BUS_WAIT_EN
    // Memory strobe syncs reset to "held" for the same reason as iow.
    logic [1:0]  msync1_reg, msync2_reg;
    logic        mem_act, mem_act_prev_reg;
    wait_state_t state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;

    assign mem_act = mem_cs & ~(&msync2_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            msync1_reg       <= 2'b00;
            msync2_reg       <= 2'b00;
            mem_act_prev_reg <= 1'b1;
            state_reg        <= WAIT_IDLE;
            cnt_reg          <= 4'd0;
        end else begin
            msync1_reg       <= {bus_memr_l, bus_memw_l};
            msync2_reg       <= msync1_reg;
            mem_act_prev_reg <= mem_act;
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            WAIT_IDLE: begin
                if (mem_act && !mem_act_prev_reg) begin
                    state_next = WAIT_WAIT;
                    cnt_next   = 4'(WAIT_CYCLES);
                end
            end
            WAIT_WAIT: begin
                if (cnt_reg <= 4'd1) begin
                    state_next = WAIT_READY;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            WAIT_READY: begin
                if (!mem_act) begin
                    state_next = WAIT_IDLE;
                end
            end
            default: state_next = WAIT_IDLE;
        endcase
    end

    assign bus_rdy = (state_reg != WAIT_WAIT);
`else
    logic unused_mem;
    assign unused_mem = &{1'b0, bus_memr_l, bus_memw_l, mem_cs};
    assign bus_rdy    = 1'b1;
`endif

endmodule

// File: tb/tb_cga_vgate_regs.sv
// Randomized self-checking bench for cga_vgate_regs against a register-level
// reference model; the wait-state scenario follows CGA_BUS_WAIT_EN.
module tb_cga_vgate_regs;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] bus_a = 15'h0;
    logic        bus_ior_l = 1'b1, bus_iow_l = 1'b1;
    logic        bus_memr_l = 1'b1, bus_memw_l = 1'b1;
    logic        mem_cs = 1'b0, bus_aen = 1'b0;
    logic [7:0]  bus_d = 8'h0;
    logic [7:0]  bus_out;
    logic        bus_dir, bus_rdy;
    logic        vsync_l = 1'b1, display_enable = 1'b0;
    logic [7:0]  control_reg, color_reg;
    logic [3:0]  tandy_mode, border_col, pal_mask;
    logic [3:0]  pal_rd_idx = 4'h0;
    logic [3:0]  pal_rd_data;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] m_ctrl, m_color;
    logic [3:0] m_mask, m_border, m_mode;
    int         m_idx;
    logic [3:0] m_pal [16];

    cga_vgate_regs dut (
        .clk(clk), .reset(reset), .bus_a(bus_a),
        .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l),
        .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l),
        .mem_cs(mem_cs), .bus_aen(bus_aen), .bus_d(bus_d),
        .bus_out(bus_out), .bus_dir(bus_dir), .bus_rdy(bus_rdy),
        .vsync_l(vsync_l), .display_enable(display_enable),
        .control_reg(control_reg), .color_reg(color_reg),
        .tandy_mode(tandy_mode), .border_col(border_col), .pal_mask(pal_mask),
        .pal_rd_idx(pal_rd_idx), .pal_rd_data(pal_rd_data)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ctrl = 8'h29; m_color = 8'h00;
        m_mask = 4'hF; m_border = 4'h0; m_mode = 4'h0;
        m_idx = 0;
        for (int i = 0; i < 16; i++) m_pal[i] = 4'(i);
    endtask

    task automatic model_write(input logic [14:0] a, input logic [7:0] d, input logic aen);
        if (aen || (a >> 4) != 15'h03D) return;
        case (a & 15'hF)
            15'h8: m_ctrl = d;
            15'h9: m_color = d;
            15'hA: m_idx = d & 8'h1F;
            15'hE: begin
                if (m_idx == 1) m_mask = d[3:0];
                if (m_idx == 2) m_border = d[3:0];
                if (m_idx == 3) m_mode = d[3:0];
                if (m_idx >= 16) begin
                    m_pal[m_idx - 16] = d[3:0];
                    m_idx = 16 + ((m_idx - 16 + 1) % 16);
                end
            end
            default: ;
        endcase
    endtask

    task automatic io_write(input logic [14:0] a, input logic [7:0] d, input logic aen);
        @(posedge clk); #1;
        bus_a = a; bus_d = d; bus_aen = aen; bus_iow_l = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus_iow_l = 1'b1; bus_aen = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        model_write(a, d, aen);
        $display("io wr a=%h d=%h aen=%0d", a, d, aen);
    endtask

    task automatic read_pal(input int i, output logic [3:0] v);
        @(posedge clk); #1 pal_rd_idx = 4'(i);
        @(posedge clk); #1 v = pal_rd_data;
    endtask

    task automatic test_reset();
        logic [3:0] v;
        reset = 1'b1; model_reset();
        repeat (2) @(posedge clk); #1;
        n_vec++; if (control_reg !== 8'h29) begin n_err++; $display("FAIL rst_ctrl got=%h exp=29", control_reg); end
        n_vec++; if (color_reg !== 8'h00) begin n_err++; $display("FAIL rst_color got=%h exp=00", color_reg); end
        n_vec++; if ({pal_mask, border_col, tandy_mode} !== 12'hF00) begin n_err++; $display("FAIL rst_idxregs got=%h exp=F00", {pal_mask, border_col, tandy_mode}); end
        n_vec++; if (pal_rd_data !== 4'h0) begin n_err++; $display("FAIL rst_paldata got=%h exp=0", pal_rd_data); end
        n_vec++; if ({bus_rdy, bus_dir, bus_out} !== 10'h200) begin n_err++; $display("FAIL rst_bus got=%h exp=200", {bus_rdy, bus_dir, bus_out}); end
        reset = 1'b0;
        repeat (4) @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            read_pal(i, v);
            n_vec++; if (v !== 4'(i)) begin n_err++; $display("FAIL rst_pal[%0d] got=%h exp=%h", i, v, 4'(i)); end
        end
        $display("reset checked");
    endtask

    task automatic test_status();
        logic [7:0] exp;
        vsync_l = 1'b0; display_enable = 1'b1;
        repeat (3) @(posedge clk); #1;
        bus_a = 15'h3DA; bus_ior_l = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_vec++; if (bus_out !== 8'hF4 || bus_dir !== 1'b1) begin n_err++; $display("FAIL status_f4 got=%h/%b exp=F4/1", bus_out, bus_dir); end
        // Two-clock reflection latency
        vsync_l = 1'b1; display_enable = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (bus_out !== 8'hF4) begin n_err++; $display("FAIL status_lat1 got=%h exp=F4", bus_out); end
        @(posedge clk); #1;
        n_vec++; if (bus_out !== 8'hFD) begin n_err++; $display("FAIL status_lat2 got=%h exp=FD", bus_out); end
        for (int k = 0; k < 8; k++) begin
            vsync_l = 1'($urandom); display_enable = 1'($urandom);
            repeat (2) @(posedge clk); #1;
            exp = {4'hF, vsync_l, 2'b10, ~display_enable};
            n_vec++; if (bus_out !== exp) begin n_err++; $display("FAIL status_rand got=%h exp=%h", bus_out, exp); end
            $display("status vs=%b de=%b out=%h", vsync_l, display_enable, bus_out);
        end
        bus_a = 15'h3D8;
        #1;
        n_vec++; if (bus_dir !== 1'b0 || bus_out !== 8'h00) begin n_err++; $display("FAIL status_other got=%h/%b exp=00/0", bus_out, bus_dir); end
        bus_ior_l = 1'b1;
        repeat (3) @(posedge clk); #1;
        bus_a = 15'h3DA;
        #1;
        n_vec++; if (bus_dir !== 1'b0 || bus_out !== 8'h00) begin n_err++; $display("FAIL status_idle got=%h/%b exp=00/0", bus_out, bus_dir); end
    endtask

    task automatic test_palette_seq();
        logic [3:0] v;
        io_write(15'h3DA, 8'h10, 1'b0);
        io_write(15'h3DE, 8'h0C, 1'b0);
        io_write(15'h3DE, 8'h0A, 1'b0);
        io_write(15'h3DE, 8'h05, 1'b0);
        io_write(15'h3DE, 8'h09, 1'b0);  // lands in entry 3 iff index reached 0x13
        for (int i = 0; i < 4; i++) begin
            read_pal(i, v);
            n_vec++; if (v !== m_pal[i]) begin n_err++; $display("FAIL palseq[%0d] got=%h exp=%h", i, v, m_pal[i]); end
        end
        @(posedge clk); #1 pal_rd_idx = 4'd1;
        @(posedge clk); #1;
        n_vec++; if (pal_rd_data !== 4'hA) begin n_err++; $display("FAIL palrd_next got=%h exp=A", pal_rd_data); end
        io_write(15'h3DA, 8'h1F, 1'b0);
        io_write(15'h3DE, 8'h07, 1'b0);
        io_write(15'h3DE, 8'h03, 1'b0);  // wrapped index targets entry 0
        read_pal(15, v);
        n_vec++; if (v !== 4'h7) begin n_err++; $display("FAIL palwrap15 got=%h exp=7", v); end
        read_pal(0, v);
        n_vec++; if (v !== 4'h3) begin n_err++; $display("FAIL palwrap0 got=%h exp=3", v); end
    endtask

    task automatic test_rdw();
        logic [3:0] old_v, new_v;
        io_write(15'h3DA, 8'h15, 1'b0);
        old_v = m_pal[5];
        new_v = ~old_v;
        pal_rd_idx = 4'd5;
        @(posedge clk); #1;
        bus_a = 15'h3DE; bus_d = {4'h0, new_v}; bus_iow_l = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_vec++; if (pal_rd_data !== old_v) begin n_err++; $display("FAIL rdw_old got=%h exp=%h", pal_rd_data, old_v); end
        @(posedge clk); #1;
        n_vec++; if (pal_rd_data !== new_v) begin n_err++; $display("FAIL rdw_new got=%h exp=%h", pal_rd_data, new_v); end
        bus_iow_l = 1'b1;
        repeat (4) @(posedge clk); #1;
        model_write(15'h3DE, {4'h0, new_v}, 1'b0);
        $display("rdw entry5 old=%h new=%h", old_v, new_v);
    endtask

    task automatic test_latency();
        @(posedge clk); #1;
        bus_a = 15'h3D9; bus_d = 8'h5C; bus_iow_l = 1'b0;
        repeat (2) @(posedge clk); #1;
        n_vec++; if (color_reg !== m_color) begin n_err++; $display("FAIL lat_early got=%h exp=%h", color_reg, m_color); end
        @(posedge clk); #1;
        n_vec++; if (color_reg !== 8'h5C) begin n_err++; $display("FAIL lat_3clk got=%h exp=5C", color_reg); end
        bus_iow_l = 1'b1;
        repeat (4) @(posedge clk); #1;
        model_write(15'h3D9, 8'h5C, 1'b0);
        $display("latency 3D9=5C");
    endtask

    task automatic test_hold();
        @(posedge clk); #1;
        bus_a = 15'h3D8; bus_d = 8'h1A; bus_iow_l = 1'b0;
        repeat (6) @(posedge clk); #1 bus_d = 8'h0A;
        repeat (14) @(posedge clk); #1;
        n_vec++; if (control_reg !== 8'h1A) begin n_err++; $display("FAIL hold_low got=%h exp=1A", control_reg); end
        bus_iow_l = 1'b1;
        repeat (4) @(posedge clk); #1;
        model_write(15'h3D8, 8'h1A, 1'b0);
        n_vec++; if (control_reg !== 8'h1A) begin n_err++; $display("FAIL hold_rel got=%h exp=1A", control_reg); end
        $display("hold 3D8 20 clocks");
    endtask

    task automatic test_aen();
        io_write(15'h3D9, 8'h00, 1'b0);
        io_write(15'h3D9, 8'h3F, 1'b1);
        n_vec++; if (color_reg !== 8'h00) begin n_err++; $display("FAIL aen_block got=%h exp=00", color_reg); end
    endtask

    task automatic test_reset_mid_write();
        @(posedge clk); #1;
        bus_a = 15'h3D8; bus_d = 8'h55; bus_iow_l = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
        repeat (6) @(posedge clk); #1;
        n_vec++; if (control_reg !== 8'h29) begin n_err++; $display("FAIL rst_midwr got=%h exp=29", control_reg); end
        bus_iow_l = 1'b1;
        repeat (4) @(posedge clk); #1;
        $display("reset during 3D8 write");
    endtask

    task automatic test_random();
        logic [14:0] a;
        logic [7:0]  d;
        logic        aen;
        logic [3:0]  v;
        int          e;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 9))
                0:       a = 15'($urandom);
                1:       a = 15'h3D0 | 15'($urandom_range(0, 15));
                2, 3:    a = 15'h3DA;
                4:       a = 15'h3D8;
                5:       a = 15'h3D9;
                default: a = 15'h3DE;
            endcase
            d = 8'($urandom);
            if (a == 15'h3DA && $urandom_range(0, 1) == 1) d = 8'h10 | 8'($urandom_range(0, 15));
            aen = ($urandom_range(0, 7) == 0);
            io_write(a, d, aen);
            n_vec++; if ({control_reg, color_reg} !== {m_ctrl, m_color}) begin n_err++; $display("FAIL rnd_cc got=%h exp=%h", {control_reg, color_reg}, {m_ctrl, m_color}); end
            n_vec++; if ({pal_mask, border_col, tandy_mode} !== {m_mask, m_border, m_mode}) begin n_err++; $display("FAIL rnd_idx got=%h exp=%h", {pal_mask, border_col, tandy_mode}, {m_mask, m_border, m_mode}); end
            e = $urandom_range(0, 15);
            read_pal(e, v);
            n_vec++; if (v !== m_pal[e]) begin n_err++; $display("FAIL rnd_pal[%0d] got=%h exp=%h", e, v, m_pal[e]); end
        end
    endtask

    task automatic test_wait();
        logic exp_rdy;
`ifdef CGA_BUS_WAIT_EN
        @(posedge clk); #1 bus_memr_l = 1'b0; mem_cs = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            exp_rdy = !(k >= 3 && k <= 6);
            n_vec++; if (bus_rdy !== exp_rdy) begin n_err++; $display("FAIL wait_k%0d got=%b exp=%b", k, bus_rdy, exp_rdy); end
        end
        bus_memr_l = 1'b1; mem_cs = 1'b0;
        repeat (5) @(posedge clk); #1;
        $display("wait access 4 states");
        bus_memw_l = 1'b0; mem_cs = 1'b1;
        repeat (4) @(posedge clk); #1;
        n_vec++; if (bus_rdy !== 1'b0) begin n_err++; $display("FAIL wait_mid got=%b exp=0", bus_rdy); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (bus_rdy !== 1'b1) begin n_err++; $display("FAIL wait_rst got=%b exp=1", bus_rdy); end
        reset = 1'b0; model_reset();
        bus_memw_l = 1'b1; mem_cs = 1'b0;
        repeat (5) @(posedge clk); #1;
        $display("reset during wait");
        bus_memr_l = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            n_vec++; if (bus_rdy !== 1'b1) begin n_err++; $display("FAIL wait_nocs k%0d got=%b exp=1", k, bus_rdy); end
        end
        bus_memr_l = 1'b1;
`else
        exp_rdy = 1'b1;
        @(posedge clk); #1 bus_memr_l = 1'b0; mem_cs = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            n_vec++; if (bus_rdy !== exp_rdy) begin n_err++; $display("FAIL rdy_tied k%0d got=%b exp=1", k, bus_rdy); end
        end
        bus_memr_l = 1'b1; mem_cs = 1'b0;
`endif
        repeat (4) @(posedge clk); #1;
        $display("mem access checked");
    endtask

    initial begin
        test_reset();
        test_status();
        test_palette_seq();
        test_rdw();
        test_latency();
        test_hold();
        test_aen();
        test_reset_mid_write();
        test_random();
        test_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
